// File: rtl/upsample_pkg.sv
// upsample_pkg: shared types and helpers for the 2x upsample controller.
//   ups_state_e  - controller FSM states
//   WM_TL..WM_BR - write_mode region codes (3*rowclass + colclass)
//   size_legal() - size_sel legality against the largest input side
package upsample_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SWEEP = 2'd2,
        ST_DONE  = 2'd3
    } ups_state_e;

    // Region codes: row class (first/interior/last) * 3 + column class.
    localparam logic [3:0] WM_TL = 4'd0;
    localparam logic [3:0] WM_T  = 4'd1;
    localparam logic [3:0] WM_TR = 4'd2;
    localparam logic [3:0] WM_L  = 4'd3;
    localparam logic [3:0] WM_C  = 4'd4;
    localparam logic [3:0] WM_R  = 4'd5;
    localparam logic [3:0] WM_BL = 4'd6;
    localparam logic [3:0] WM_B  = 4'd7;
    localparam logic [3:0] WM_BR = 4'd8;

    // Side N = 2^(sel+2) must not exceed 2^max_log2.
    function automatic logic size_legal(input logic [2:0] sel, input int max_log2);
        return int'(sel) <= (max_log2 - 2);
    endfunction

endpackage

// File: rtl/upsample_addr_gen.sv
// upsample_addr_gen: combinational address / region decode for one pixel.
//   r, c, ch   in  - current row, column, channel (registered in the parent)
//   lg         in  - log2 of the input side N
//   rd_addr    out - ch*N*N + r*N + c
//   wr_addr    out - ch*4*N*N + 2r*2N + 2c (top-left of the 2x2 output block)
//   write_mode out - region code WM_TL..WM_BR
//   row_last, col_last out - r / c at N-1, used by the parent's counters
module upsample_addr_gen
    import upsample_pkg::*;
#(
    parameter int MAX_LOG2 = 6,
    parameter int CHW      = 2,
    parameter int LGW      = 3,
    parameter int RAW      = 14,
    parameter int WAW      = 16
) (
    input  logic [MAX_LOG2-1:0] r,
    input  logic [MAX_LOG2-1:0] c,
    input  logic [CHW-1:0]      ch,
    input  logic [LGW-1:0]      lg,
    output logic [RAW-1:0]      rd_addr,
    output logic [WAW-1:0]      wr_addr,
    output logic [3:0]          write_mode,
    output logic                row_last,
    output logic                col_last
);

    logic [MAX_LOG2-1:0] last_idx;
    logic [LGW+1:0]      sh_plane;
    logic [LGW+1:0]      sh_wplane;
    logic [LGW+1:0]      sh_wrow;
    logic [1:0]          rcls;
    logic [1:0]          ccls;

    // N-1 as a mask: low lg bits set.
    assign last_idx  = ~({MAX_LOG2{1'b1}} << lg);
    assign row_last  = (r == last_idx);
    assign col_last  = (c == last_idx);

    // N is a power of two, so every multiply is a shift and the fields never overlap.
    assign sh_plane  = {1'b0, lg, 1'b0};
    assign sh_wplane = sh_plane + (LGW+2)'(2);
    assign sh_wrow   = {2'b00, lg} + (LGW+2)'(2);

    assign rd_addr = (RAW'(ch) << sh_plane) | (RAW'(r) << lg) | RAW'(c);
    assign wr_addr = (WAW'(ch) << sh_wplane) | (WAW'(r) << sh_wrow) | WAW'({c, 1'b0});

    assign rcls = (r == '0) ? 2'd0 : (row_last ? 2'd2 : 2'd1);
    assign ccls = (c == '0) ? 2'd0 : (col_last ? 2'd2 : 2'd1);

    always_comb begin
        write_mode = WM_TL;
        case ({rcls, ccls})
            4'b0000: write_mode = WM_TL;
            4'b0001: write_mode = WM_T;
            4'b0010: write_mode = WM_TR;
            4'b0100: write_mode = WM_L;
            4'b0101: write_mode = WM_C;
            4'b0110: write_mode = WM_R;
            4'b1000: write_mode = WM_BL;
            4'b1001: write_mode = WM_B;
            4'b1010: write_mode = WM_BR;
            default: write_mode = WM_TL;
        endcase
    end

endmodule

// File: rtl/upsample_ctrl_param.sv
// upsample_ctrl_param: sequencer for a 2x nearest-neighbour upsample.
// Sweeps NUM_CH channels of an N x N input (N = 2^(size_sel+2)) one pixel
// per cycle, issuing an input read and a 2x2 output quad write per pixel.
// Optional feature macro: UPS_BACKPRESSURE_EN adds out_ready; SWEEP cycles
// with out_ready low hold the pixel position (wr_en stays asserted).
//   clk, rst        - clock, synchronous active-low reset
//   start, size_sel - frame request and input side select
//   out_ready       - quad write accepted (UPS_BACKPRESSURE_EN only)
//   busy, done, err - status: frame running, completion pulse, bad size pulse
//   rd_en, rd_addr  - input buffer read
//   wr_en, wr_addr  - output quad write (top-left address)
//   write_mode      - pixel region code, ch_idx - current channel
module upsample_ctrl_param
    import upsample_pkg::*;
#(
    parameter  int MAX_LOG2 = 6,
    parameter  int NUM_CH   = 4,
    localparam int RAW      = $clog2(NUM_CH) + 2 * MAX_LOG2,
    localparam int WAW      = RAW + 2,
    localparam int CHW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2:0]     size_sel,
`ifdef UPS_BACKPRESSURE_EN
    input  logic           out_ready,
`endif
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic           rd_en,
    output logic [RAW-1:0] rd_addr,
    output logic           wr_en,
    output logic [WAW-1:0] wr_addr,
    output logic [3:0]     write_mode,
    output logic [CHW-1:0] ch_idx
);

    localparam int LGW = $clog2(MAX_LOG2 + 1);

    ups_state_e          state, nxt;
    logic [MAX_LOG2-1:0] r_q, c_q;
    logic [CHW-1:0]      ch_q;
    logic [LGW-1:0]      lg_q;
    logic                err_q;
    logic                legal, accept, adv;
    logic                row_last, col_last, ch_last;

    assign legal   = size_legal(size_sel, MAX_LOG2);
    assign accept  = (state == ST_IDLE) && start && legal;
    assign ch_last = (ch_q == CHW'(NUM_CH - 1));

`ifdef UPS_BACKPRESSURE_EN
    assign adv = (state == ST_SWEEP) && out_ready;
`else
    assign adv = (state == ST_SWEEP);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= nxt;
    end

    // Next state
    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:  if (accept) nxt = ST_LOAD;
            ST_LOAD:  nxt = ST_SWEEP;
            ST_SWEEP: if (adv && row_last && col_last && ch_last) nxt = ST_DONE;
            ST_DONE:  nxt = ST_IDLE;
            default:  nxt = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        rd_en = 1'b0;
        wr_en = 1'b0;
        case (state)
            ST_LOAD:  busy = 1'b1;
            ST_SWEEP: begin
                busy  = 1'b1;
                rd_en = 1'b1;
                wr_en = 1'b1;
            end
            ST_DONE:  done = 1'b1;
            default:  ;
        endcase
    end

    // Bad-size pulse; a start while busy is not in IDLE and never flags.
    always_ff @(posedge clk) begin
        if (!rst) err_q <= 1'b0;
        else      err_q <= (state == ST_IDLE) && start && !legal;
    end
    assign err = err_q;

    // Pixel position. N is captured at accept so later size_sel changes are ignored.
    // On the very last pixel ch stays put; the FSM leaves SWEEP on that edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q  <= '0;
            c_q  <= '0;
            ch_q <= '0;
            lg_q <= LGW'(2);
        end else if (accept) begin
            r_q  <= '0;
            c_q  <= '0;
            ch_q <= '0;
            lg_q <= LGW'({1'b0, size_sel} + 4'd2);
        end else if (adv) begin
            if (col_last) begin
                c_q <= '0;
                if (row_last) begin
                    r_q <= '0;
                    if (!ch_last) ch_q <= ch_q + 1'b1;
                end else begin
                    r_q <= r_q + 1'b1;
                end
            end else begin
                c_q <= c_q + 1'b1;
            end
        end
    end

    assign ch_idx = ch_q;

    upsample_addr_gen #(
        .MAX_LOG2 (MAX_LOG2),
        .CHW      (CHW),
        .LGW      (LGW),
        .RAW      (RAW),
        .WAW      (WAW)
    ) u_addr (
        .r          (r_q),
        .c          (c_q),
        .ch         (ch_q),
        .lg         (lg_q),
        .rd_addr    (rd_addr),
        .wr_addr    (wr_addr),
        .write_mode (write_mode),
        .row_last   (row_last),
        .col_last   (col_last)
    );

endmodule

// File: tb/tb_upsample_ctrl_param.sv
// tb_upsample_ctrl_param: self-checking bench for upsample_ctrl_param.
// Two instances: u1 (NUM_CH=1) and u4 (NUM_CH=4), both MAX_LOG2=6.
// Expected pixel streams come from a queue model built with plain arithmetic.
module tb_upsample_ctrl_param;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       start1 = 1'b0, start4 = 1'b0;
    logic [2:0] sel1 = 3'd0, sel4 = 3'd0;
    logic       rdy = 1'b1;

    logic        busy1, done1, err1, rd_en1, wr_en1;
    logic [11:0] rd1;
    logic [13:0] wr1;
    logic [3:0]  wm1;
    logic [0:0]  ch1;

    logic        busy4, done4, err4, rd_en4, wr_en4;
    logic [13:0] rd4;
    logic [15:0] wr4;
    logic [3:0]  wm4;
    logic [1:0]  ch4;

    int total  = 0;
    int passed = 0;

    upsample_ctrl_param #(.MAX_LOG2(6), .NUM_CH(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .size_sel(sel1),
`ifdef UPS_BACKPRESSURE_EN
        .out_ready(rdy),
`endif
        .busy(busy1), .done(done1), .err(err1), .rd_en(rd_en1), .rd_addr(rd1),
        .wr_en(wr_en1), .wr_addr(wr1), .write_mode(wm1), .ch_idx(ch1)
    );

    upsample_ctrl_param #(.MAX_LOG2(6), .NUM_CH(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .size_sel(sel4),
`ifdef UPS_BACKPRESSURE_EN
        .out_ready(rdy),
`endif
        .busy(busy4), .done(done4), .err(err4), .rd_en(rd_en4), .rd_addr(rd4),
        .wr_en(wr_en4), .wr_addr(wr4), .write_mode(wm4), .ch_idx(ch4)
    );

    // ---------------- reference model ----------------
    typedef struct { int rd; int wr; int wm; int ch; } pix_t;
    pix_t q[$];

    int exp_wm[16] = '{0,1,1,2,3,4,4,5,3,4,4,5,6,7,7,8};

    function automatic int cls(input int i, input int n);
        if (i == 0)     return 0;
        if (i == n - 1) return 2;
        return 1;
    endfunction

    task automatic build_model(input int nch, input int n);
        pix_t p;
        q.delete();
        for (int ch = 0; ch < nch; ch++)
            for (int r = 0; r < n; r++)
                for (int c = 0; c < n; c++) begin
                    p.rd = ch * n * n + r * n + c;
                    p.wr = ch * 4 * n * n + (2 * r) * (2 * n) + 2 * c;
                    p.wm = 3 * cls(r, n) + cls(c, n);
                    p.ch = ch;
                    q.push_back(p);
                end
    endtask

    // Runs one u4 frame against the model. mode: 0 always ready,
    // 1 random ready, 2 ready low for 3 cycles at pixel 5.
    task automatic run_u4_frame(input int sel, input int mode, input bit stray,
                                output int adv_cnt, output int stall_cnt,
                                output int ch2_wr, output int done_cyc);
        int   n, cyc, stall_left;
        bit   err_seen, stalled;
        pix_t e;
        n = 1 << (sel + 2);
        build_model(4, n);
        err_seen = 0; stalled = 0; stall_left = 0;
        adv_cnt = 0; stall_cnt = 0; ch2_wr = -1; done_cyc = 0;
        @(negedge clk); sel4 = 3'(sel); start4 = 1'b1;
        @(negedge clk); start4 = 1'b0; cyc = 1;
        total++;
        if ({busy4, wr_en4, err4} !== 3'b100)
            $display("FAIL load_cycle busy/wr_en/err got %b want 100", {busy4, wr_en4, err4});
        else passed++;
        while (done_cyc == 0 && cyc < 5000) begin
`ifdef UPS_BACKPRESSURE_EN
            if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
            else if (mode == 2) begin
                if (!stalled && adv_cnt == 5 && wr_en4) begin stalled = 1; stall_left = 3; end
                rdy = (stall_left == 0);
                if (stall_left > 0) stall_left--;
            end else rdy = 1'b1;
`else
            rdy = 1'b1;
`endif
            if (stray) begin
                start4 = wr_en4 && ($urandom_range(0, 5) == 0);
                sel4   = 3'($urandom_range(0, 7));
            end
            if (err4) err_seen = 1;
            if (wr_en4) begin
                total++;
                if (q.size() == 0) begin
                    $display("FAIL extra_write wr_addr got %0d want no write", wr4);
                end else begin
                    e = q[0];
                    if ({busy4, rd_en4, rd4, wr4, wm4, ch4} !==
                        {2'b11, 14'(e.rd), 16'(e.wr), 4'(e.wm), 2'(e.ch)})
                        $display("FAIL pixel%0d rd/wr/wm/ch got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                                 adv_cnt, rd4, wr4, wm4, ch4, e.rd, e.wr, e.wm, e.ch);
                    else passed++;
                    if (rdy) begin
                        if (e.ch == 2 && ch2_wr < 0) ch2_wr = int'(wr4);
                        void'(q.pop_front());
                        adv_cnt++;
                    end else stall_cnt++;
                end
            end
            if (done4) done_cyc = cyc;
            @(negedge clk); cyc++;
        end
        start4 = 1'b0; rdy = 1'b1;
        total++;
        if (done_cyc != 4 * n * n + 2 + stall_cnt)
            $display("FAIL done_cycle got %0d want %0d", done_cyc, 4 * n * n + 2 + stall_cnt);
        else passed++;
        total++;
        if (q.size() != 0) $display("FAIL pixels_left got %0d want 0", q.size());
        else passed++;
        total++;
        if (err_seen) $display("FAIL err_during_frame got 1 want 0");
        else passed++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy1, done1, err1, rd_en1, wr_en1, rd1, wr1, wm1, ch1} !== '0)
            $display("FAIL reset_u1 outputs got %h want 0", {busy1, done1, err1, rd_en1, wr_en1, rd1, wr1, wm1, ch1});
        else passed++;
        total++;
        if ({busy4, done4, err4, rd_en4, wr_en4, rd4, wr4, wm4, ch4} !== '0)
            $display("FAIL reset_u4 outputs got %h want 0", {busy4, done4, err4, rd_en4, wr_en4, rd4, wr4, wm4, ch4});
        else passed++;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({busy1, busy4} !== 2'b00) $display("FAIL idle_busy got %b want 00", {busy1, busy4});
        else passed++;
    endtask

    task automatic test_small_frame();
        int cyc, k, done_cyc;
        @(negedge clk); sel1 = 3'd0; start1 = 1'b1;
        @(negedge clk); start1 = 1'b0; cyc = 1; k = 0; done_cyc = 0;
        while (done_cyc == 0 && cyc < 100) begin
            if (wr_en1) begin
                if (k < 16) begin
                    total++;
                    if (int'(wm1) != exp_wm[k]) $display("FAIL wm_seq[%0d] got %0d want %0d", k, wm1, exp_wm[k]);
                    else passed++;
                end
                if (k == 6) begin
                    total++;
                    if (rd1 !== 12'd6 || wr1 !== 14'd20)
                        $display("FAIL r1c2_addr rd/wr got %0d/%0d want 6/20", rd1, wr1);
                    else passed++;
                end
                k++;
            end
            if (done1) done_cyc = cyc;
            @(negedge clk); cyc++;
        end
        total++;
        if (done_cyc != 18) $display("FAIL small_done_cycle got %0d want 18", done_cyc);
        else passed++;
        total++;
        if (k != 16) $display("FAIL small_pixels got %0d want 16", k);
        else passed++;
    endtask

    task automatic test_four_ch();
        int adv, stl, ch2, dc;
        run_u4_frame(1, 0, 0, adv, stl, ch2, dc);
        total++;
        if (ch2 != 512) $display("FAIL ch2_first_wr got %0d want 512", ch2);
        else passed++;
        total++;
        if (adv != 256 || dc != 258) $display("FAIL four_ch adv/done got %0d/%0d want 256/258", adv, dc);
        else passed++;
    endtask

    task automatic test_err();
        int bad;
        for (int s = 5; s <= 7; s++) begin
            @(negedge clk); sel4 = 3'(s); start4 = 1'b1;
            @(negedge clk); start4 = 1'b0;
            total++;
            if ({err4, busy4, wr_en4} !== 3'b100)
                $display("FAIL err_pulse sel=%0d err/busy/wr_en got %b want 100", s, {err4, busy4, wr_en4});
            else passed++;
            bad = 0;
            repeat (4) begin
                @(negedge clk);
                if (err4 || busy4 || wr_en4) bad++;
            end
            total++;
            if (bad != 0) $display("FAIL err_after sel=%0d active cycles got %0d want 0", s, bad);
            else passed++;
        end
    endtask

    task automatic test_max_size();
        int cyc, k, done_cyc, last_rd, last_wr, last_wm;
        bit e_seen;
        @(negedge clk); sel1 = 3'd4; start1 = 1'b1;
        @(negedge clk); start1 = 1'b0; cyc = 1; k = 0; done_cyc = 0; e_seen = 0;
        last_rd = -1; last_wr = -1; last_wm = -1;
        while (done_cyc == 0 && cyc < 4300) begin
            if (err1) e_seen = 1;
            if (wr_en1) begin k++; last_rd = int'(rd1); last_wr = int'(wr1); last_wm = int'(wm1); end
            if (done1) done_cyc = cyc;
            @(negedge clk); cyc++;
        end
        total++;
        if (done_cyc != 4098 || k != 4096 || e_seen)
            $display("FAIL max_size done/pixels/err got %0d/%0d/%0d want 4098/4096/0", done_cyc, k, e_seen);
        else passed++;
        total++;
        if (last_rd != 63 * 64 + 63 || last_wr != 126 * 128 + 126 || last_wm != 8)
            $display("FAIL max_size_last rd/wr/wm got %0d/%0d/%0d want %0d/%0d/8",
                     last_rd, last_wr, last_wm, 63 * 64 + 63, 126 * 128 + 126);
        else passed++;
    endtask

`ifdef UPS_BACKPRESSURE_EN
    task automatic test_stall();
        int adv, stl, ch2, dc;
        run_u4_frame(0, 2, 0, adv, stl, ch2, dc);
        total++;
        if (stl != 3 || dc != 4 * 16 + 2 + 3)
            $display("FAIL stall stalls/done got %0d/%0d want 3/%0d", stl, dc, 4 * 16 + 2 + 3);
        else passed++;
    endtask
`endif

    task automatic test_reset_mid();
        int cnt, cyc, dones, adv, stl, ch2, dc;
        @(negedge clk); sel4 = 3'd1; start4 = 1'b1;
        @(negedge clk); start4 = 1'b0; cnt = 0; cyc = 0;
        while (cnt < 10 && cyc < 100) begin
            if (wr_en4) cnt++;
            @(negedge clk); cyc++;
        end
        total++;
        if (rd4 !== 14'(1 * 8 + 2)) $display("FAIL mid_pixel10 rd got %0d want %0d", rd4, 1 * 8 + 2);
        else passed++;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({busy4, done4, err4, rd_en4, wr_en4, rd4, wr4, wm4, ch4} !== '0)
                $display("FAIL mid_reset[%0d] outputs got %h want 0", i,
                         {busy4, done4, err4, rd_en4, wr_en4, rd4, wr4, wm4, ch4});
            else passed++;
        end
        rst = 1'b1;
        dones = 0;
        repeat (300) begin
            @(negedge clk);
            if (done4) dones++;
        end
        total++;
        if (dones != 0) $display("FAIL mid_reset_done got %0d want 0", dones);
        else passed++;
        run_u4_frame(1, 0, 0, adv, stl, ch2, dc);
    endtask

    task automatic test_random();
        int adv, stl, ch2, dc, sel;
        repeat (6) begin
            sel = $urandom_range(0, 2);
            run_u4_frame(sel, 1, 1, adv, stl, ch2, dc);
        end
    endtask

    initial begin
        test_reset();
        test_small_frame();
        test_four_ch();
        test_err();
        test_max_size();
`ifdef UPS_BACKPRESSURE_EN
        test_stall();
`endif
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached, passed %0d of %0d", passed, total);
        $fatal(1);
    end

endmodule

// File: doc/upsample_ctrl_param.md
UPSAMPLE_CTRL_PARAM -- requirements
Module: upsample_ctrl_param

Interface
REQ-001 SHALL have parameter MAX_LOG2, default 6, meaning the largest input side is 2^MAX_LOG2 (64).
REQ-002 SHALL have parameter NUM_CH, default 4, meaning channels processed per start.
REQ-003 SHALL derive localparams RAW = log2(NUM_CH)+2*MAX_LOG2 and WAW = RAW+2.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 start  in  1  one-cycle request to begin a frame.
REQ-007 size_sel  in  3  input side N = 2^(size_sel+2); legal 0..MAX_LOG2-2.
REQ-008 out_ready  in  1  datapath can accept a quad write (present only under UPS_BACKPRESSURE_EN).
REQ-009 busy  out  1  high from accepted start until DONE.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 err  out  1  one-cycle pulse on illegal size_sel at start.
REQ-012 rd_en  out  1  input-buffer read strobe.
REQ-013 rd_addr  out  RAW  = ch*N*N + r*N + c.
REQ-014 wr_en  out  1  output quad write strobe (valid).
REQ-015 wr_addr  out  WAW  = ch*4*N*N + (2r)*(2N) + 2c, top-left of the 2x2 output block.
REQ-016 write_mode  out  4  region code for the current pixel.
REQ-017 ch_idx  out  log2(NUM_CH)  current channel.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, SWEEP, DONE.
REQ-019 IDLE->LOAD on start with legal size_sel; N is latched and r, c, ch are cleared.
REQ-020 IDLE->IDLE with err=1 for one cycle when start arrives with size_sel>MAX_LOG2-2.
REQ-021 LOAD SHALL last exactly one cycle, with rd_en=wr_en=0, and always go to SWEEP.
REQ-022 In SWEEP, rd_en=wr_en=1 every cycle; an advance is a SWEEP cycle with (out_ready or macro absent).
REQ-023 On an advance: c++; when c==N-1, c->0 and r++; when r==N-1 and c==N-1, r->0 and ch++.
REQ-024 The advance on the last pixel of channel NUM_CH-1 SHALL go to DONE.
REQ-025 DONE SHALL last one cycle with done=1, busy=0, then go to IDLE.
REQ-026 write_mode SHALL be 3*rowclass+colclass, where class is 0 for first, 1 for interior, 2 for last (row or column).
REQ-027 write_mode values SHALL therefore range 0 (top-left) to 8 (bottom-right); values 9..15 are unused.
REQ-028 rd_addr, wr_addr, write_mode and ch_idx SHALL be combinational from registered r, c, ch, N.
REQ-029 Those outputs SHALL be valid in the same cycle as wr_en.
REQ-030 start while busy SHALL be ignored, with no err.
REQ-031 size_sel changes after LOAD SHALL not affect the frame in progress.
REQ-032 Throughput SHALL be one pixel per cycle without stall.
REQ-033 Frame length SHALL be NUM_CH*N*N SWEEP advances plus 2 cycles.

Reset
REQ-034 rst=0 SHALL force IDLE and set busy, done, err, rd_en, wr_en to 0.
REQ-035 rst=0 SHALL clear r, c, ch, addresses and write_mode to 0.
REQ-036 Reset mid-frame SHALL abort with no done pulse; the next start restarts at ch=0.

Configuration
REQ-037 Macro UPS_BACKPRESSURE_EN defined: out_ready exists.
REQ-038 With the macro, SWEEP cycles with out_ready=0 SHALL hold r, c, ch and all address/mode outputs stable, with wr_en still 1.
REQ-039 Macro absent: the out_ready port does not exist and SWEEP advances every cycle.

Structure
REQ-040 Package upsample_pkg SHALL hold the state enum, the write_mode localparams WM_TL..WM_BR (0..8) and the size_sel legality function.
REQ-041 Sub-module upsample_addr_gen SHALL compute rd_addr, wr_addr and write_mode from r, c, ch, N.

Verification
REQ-042 NUM_CH=1, size_sel=0: write_mode sequence SHALL be 0,1,1,2,3,4,4,5,3,4,4,5,6,7,7,8.
REQ-043 Same run: done SHALL pulse 18 cycles after the start edge; r=1,c=2 gives rd_addr=6, wr_addr=20.
REQ-044 NUM_CH=4, size_sel=1: ch_idx steps 0..3; the first wr_addr of ch=2 is 512; 256 advances occur, then done.
REQ-045 size_sel=5 with MAX_LOG2=6: one err pulse, busy stays 0, no wr_en.
REQ-046 With the macro, out_ready=0 for 3 cycles at pixel 5: wr_addr is held for 3 cycles and done is delayed by exactly 3.
REQ-047 rst=0 at pixel 10 then start: outputs are 0 during reset, there is no done, and the new frame starts at rd_addr=0.
